reg_file_sb: RTL and testbench

Parametrised multi-port register file with write-through bypass and an integrated busy scoreboard. It generalises the single fixed-width enable register into a DEPTH x WIDTH array with two combinational read ports and one write port. It optionally hardwires register 0 to zero and tracks outstanding producers per register. It sits between the decode/issue stage, which reads operands and marks destinations busy, and the writeback stage, which writes results and clears busy.

---
 rtl/reg_file_sb.sv | 115 +++++++++++
 tb/tb_reg_file_sb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port with write-through
// bypass, and a per-register busy scoreboard with a registered busy counter.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [WIDTH-1:0]  wrData,
  input  logic [ADDR_W-1:0] rdAddr1,
  input  logic [ADDR_W-1:0] rdAddr2,
  output logic [WIDTH-1:0]  rdData1,
  output logic [WIDTH-1:0]  rdData2,
  output logic              rdBusy1,
  output logic              rdBusy2,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issueAddr,
  output logic [ADDR_W:0]   busyCount,
  output logic              allClear
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  count_q;
  logic [ADDR_W:0]  count_next;
  logic             clear_q;

  logic wr_live;
  logic wr_store;
  logic issue_ok;
  logic inc;
  logic dec;
  logic byp1;
  logic byp2;

  // A live write is one that the array will see this edge; reset suppresses it.
  assign wr_live  = regWrite & ~reset;
  assign wr_store = wr_live & ~(ZR && (wrAddr == '0));
  assign issue_ok = issue & ~(ZR && (issueAddr == '0));

  assign byp1 = wr_live && (wrAddr == rdAddr1);
  assign byp2 = wr_live && (wrAddr == rdAddr2);

  always_comb begin
    rdData1 = regs[rdAddr1];
    if (ZR && (rdAddr1 == '0))
      rdData1 = '0;
    else if (byp1)
      rdData1 = wrData;
  end

  always_comb begin
    rdData2 = regs[rdAddr2];
    if (ZR && (rdAddr2 == '0))
      rdData2 = '0;
    else if (byp2)
      rdData2 = wrData;
  end

  // A same-cycle writeback makes the operand ready immediately.
  assign rdBusy1 = busy[rdAddr1] & ~byp1;
  assign rdBusy2 = busy[rdAddr2] & ~byp2;

  assign inc = issue_ok & ~busy[issueAddr];
  assign dec = regWrite & busy[wrAddr] & ~(issue_ok && (issueAddr == wrAddr));

  // Issue is applied after the clear so a new producer wins over the old writeback.
  always_comb begin
    busy_next = busy;
    if (regWrite)
      busy_next[wrAddr] = 1'b0;
    if (issue_ok)
      busy_next[issueAddr] = 1'b1;
  end

  always_comb begin
    count_next = count_q;
    if (inc && !dec)
      count_next = count_q + 1'b1;
    else if (dec && !inc)
      count_next = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_store) begin
      regs[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= '0;
      count_q <= '0;
      clear_q <= 1'b1;
    end else begin
      busy    <= busy_next;
      count_q <= count_next;
      clear_q <= (count_next == '0);
    end
  end

  assign busyCount = count_q;
  assign allClear  = clear_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: vector table for combinational reads plus a queue of
// expected busyCount/allClear values checked after each edge.
module tb_reg_file_sb;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              regWrite;
  logic [ADDR_W-1:0] wrAddr;
  logic [WIDTH-1:0]  wrData;
  logic [ADDR_W-1:0] rdAddr1;
  logic [ADDR_W-1:0] rdAddr2;
  logic [WIDTH-1:0]  rdData1;
  logic [WIDTH-1:0]  rdData2;
  logic              rdBusy1;
  logic              rdBusy2;
  logic              issue;
  logic [ADDR_W-1:0] issueAddr;
  logic [ADDR_W:0]   busyCount;
  logic              allClear;

  reg_file_sb #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .wrAddr(wrAddr), .wrData(wrData),
    .rdAddr1(rdAddr1), .rdAddr2(rdAddr2), .rdData1(rdData1), .rdData2(rdData2),
    .rdBusy1(rdBusy1), .rdBusy2(rdBusy2), .issue(issue), .issueAddr(issueAddr),
    .busyCount(busyCount), .allClear(allClear)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        iss;
    logic [4:0]  ia;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        eb1;
    logic        eb2;
    logic [5:0]  ecnt;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  logic [6:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(logic rst, logic wr, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] ra1, logic [4:0] ra2, logic iss, logic [4:0] ia,
                              logic [31:0] e1, logic [31:0] e2, logic eb1, logic eb2,
                              logic [5:0] ecnt);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wa = wa; v.wd = wd; v.ra1 = ra1; v.ra2 = ra2;
    v.iss = iss; v.ia = ia; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply inputs away from the active edge
  task automatic drive(input logic rst, input logic wr, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                       input logic iss, input logic [4:0] ia);
    @(negedge clk);
    reset = rst; regWrite = wr; wrAddr = wa; wrData = wd;
    rdAddr1 = ra1; rdAddr2 = ra2; issue = iss; issueAddr = ia;
    #1;
  endtask

  // scoreboard: push expected registered outputs, take the edge, pop and compare
  task automatic step_and_score(input logic [5:0] ecnt, input string tag);
    logic [6:0] e;
    exp_q.push_back({ecnt, (ecnt == 6'd0)});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, " busyCount"}, 32'(busyCount), 32'(e[6:1]));
      check({tag, " allClear"}, 32'(allClear), 32'(e[0]));
    end
  endtask

  initial begin
    vecs[0]  = mk(0,1, 5,32'hDEADBEEF, 5, 0,0, 0, 32'hDEADBEEF,0,0,0,0);
    vecs[1]  = mk(0,0, 0,0,            5, 5,0, 0, 32'hDEADBEEF,32'hDEADBEEF,0,0,0);
    vecs[2]  = mk(0,1, 0,32'h12345678, 0, 0,1, 0, 0,0,0,0,0);
    vecs[3]  = mk(0,0, 0,0,            0, 5,0, 0, 0,32'hDEADBEEF,0,0,0);
    vecs[4]  = mk(0,0, 0,0,            3, 7,1, 3, 0,0,0,0,1);
    vecs[5]  = mk(0,0, 0,0,            3, 7,1, 7, 0,0,1,0,2);
    vecs[6]  = mk(0,0, 0,0,            3, 7,1, 3, 0,0,1,1,2);
    vecs[7]  = mk(0,1, 3,32'hAAAA0003, 7, 3,0, 0, 0,32'hAAAA0003,1,0,1);
    vecs[8]  = mk(0,0, 0,0,            3, 7,0, 0, 32'hAAAA0003,0,0,1,1);
    vecs[9]  = mk(0,0, 0,0,            9, 7,1, 9, 0,0,0,1,2);
    vecs[10] = mk(0,1, 9,32'h99,       9, 7,1, 9, 32'h99,0,0,1,2);
    vecs[11] = mk(0,0, 0,0,            9, 9,0, 0, 32'h99,32'h99,1,1,2);
    vecs[12] = mk(0,0, 0,0,            6, 4,1, 6, 0,0,0,0,3);
    vecs[13] = mk(0,1, 6,32'h66,       6, 4,1, 4, 32'h66,0,0,0,3);
    vecs[14] = mk(0,0, 0,0,            6, 4,0, 0, 32'h66,0,0,1,3);
    vecs[15] = mk(0,1, 5,32'h55,       5, 7,0, 0, 32'h55,0,0,1,3);
    vecs[16] = mk(0,0, 0,0,            7, 5,1, 7, 0,32'h55,1,0,3);
    vecs[17] = mk(0,0, 0,0,            1, 2,1, 1, 0,0,0,0,4);
    vecs[18] = mk(0,0, 0,0,            1, 2,1, 2, 0,0,1,0,5);
    vecs[19] = mk(0,0, 0,0,            1, 2,1, 3, 0,0,1,1,6);
    vecs[20] = mk(1,1, 1,32'hFF,       1, 3,1, 8, 0,32'hAAAA0003,1,1,0);
    vecs[21] = mk(0,0, 0,0,            1, 3,0, 0, 0,0,0,0,0);
    vecs[22] = mk(0,0, 0,0,           31,31,1,31, 0,0,0,0,1);
    vecs[23] = mk(0,1,31,32'hFFFFFFFF,31,31,0, 0, 32'hFFFFFFFF,32'hFFFFFFFF,0,0,0);

    reset = 1'b1; regWrite = 1'b0; wrAddr = '0; wrData = '0;
    rdAddr1 = '0; rdAddr2 = '0; issue = 1'b0; issueAddr = '0;

    // reset state: counter, allClear, then every address reads zero and not busy
    drive(1, 1, 5'd4, 32'h1234, 0, 0, 1, 5'd4);
    step_and_score(0, "reset");
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 5'(a), 5'(31 - a), 0, 0);
      check($sformatf("reset rd1[%0d]", a), rdData1, 32'h0);
      check($sformatf("reset rd2[%0d]", 31 - a), rdData2, 32'h0);
      check($sformatf("reset busy1[%0d]", a), 32'(rdBusy1), 32'h0);
      check($sformatf("reset busy2[%0d]", 31 - a), 32'(rdBusy2), 32'h0);
    end

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].wr, vecs[i].wa, vecs[i].wd,
            vecs[i].ra1, vecs[i].ra2, vecs[i].iss, vecs[i].ia);
      check($sformatf("v%0d rdData1", i), rdData1, vecs[i].e1);
      check($sformatf("v%0d rdData2", i), rdData2, vecs[i].e2);
      check($sformatf("v%0d rdBusy1", i), 32'(rdBusy1), 32'(vecs[i].eb1));
      check($sformatf("v%0d rdBusy2", i), 32'(rdBusy2), 32'(vecs[i].eb2));
      step_and_score(vecs[i].ecnt, $sformatf("v%0d", i));
    end

    // fill every register: counter tops out at DEPTH-1 since r0 is never busy
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step_and_score(0, "refill reset");
    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, 0, 1, 5'(a));
      step_and_score(6'(a), $sformatf("fill r%0d", a));
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5'd17);
    step_and_score(6'd31, "fill again");

    // drain in random order of data; counter walks back to zero
    for (int a = 1; a < 32; a++) begin
      logic [31:0] d;
      d = $urandom_range(32'hFFFF, 1);
      drive(0, 1, 5'(a), d, 5'(a), 0, 0, 0);
      check($sformatf("drain bypass r%0d", a), rdData1, d);
      check($sformatf("drain busy r%0d", a), 32'(rdBusy1), 32'h0);
      step_and_score(6'(31 - a), $sformatf("drain r%0d", a));
      check($sformatf("drain stored r%0d", a), rdData1, d);
    end

    // writeback to an idle register never underflows the counter
    drive(0, 1, 5'd12, 32'h0BAD, 12, 0, 0, 0);
    step_and_score(0, "idle writeback");

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard leftover: %0d entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
